// File: rtl/regfile_issue_ctrl_if.sv
// rtl/regfile_issue_ctrl_if.sv - instruction packet valid/ready bus
//
// Carries one instruction packet from a producer (master) to the issue
// sequencer (slave). A packet transfers on a cycle where instr_valid and
// instr_ready are both high.
//   instr_valid  producer has a packet
//   instr_ready  consumer can accept
//   instr_op     3-bit op code
//   instr_rs1    read address 1
//   instr_rs2    read address 2
//   instr_rd     write address
//   instr_shamt  shift length
//   instr_data   immediate write data
interface regfile_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rs1;
  logic [4:0]  instr_rs2;
  logic [4:0]  instr_rd;
  logic [3:0]  instr_shamt;
  logic [15:0] instr_data;

  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
           instr_shamt, instr_data,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
           instr_shamt, instr_data,
    output instr_ready
  );
endinterface

// File: rtl/regfile_issue_ctrl.sv
// rtl/regfile_issue_ctrl.sv - instruction FIFO and issue sequencer for the register file datapath
//
// Buffers instruction packets in a DEPTH-entry FIFO and issues them one at a
// time to the multi-cycle register file datapath, holding all operands
// stable until rf_done, then reports the retirement with its cycle count.
//
// Optional feature macro: WATCHDOG_EN -- when defined, an op that runs
// TIMEOUT EXEC cycles without rf_done is force-retired and the sticky error
// flag is set. When undefined, EXEC waits indefinitely and error is 0.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   instr           slave side of regfile_issue_ctrl_if (packet input)
//   flush           synchronous FIFO flush; in-flight op is not aborted
//   rf_op_valid     datapath may count/execute (high throughout EXEC)
//   rf_op/rs1/rs2/rd/shamt/wdata  issued operands, held outside EXEC
//   rf_done         one-cycle completion pulse from the datapath
//   busy            sequencer active or FIFO non-empty
//   retire_valid    one-cycle retirement pulse
//   retire_op       op of the retired packet
//   retire_cycles   EXEC cycles including the rf_done cycle, saturating
//   retired_cnt     total retirements, wrapping
//   error           sticky watchdog flag
module regfile_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int CYC_W   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_issue_ctrl_if.slave   instr,
  input  logic                  flush,
  output logic                  rf_op_valid,
  output logic [2:0]            rf_op,
  output logic [4:0]            rf_rs1,
  output logic [4:0]            rf_rs2,
  output logic [4:0]            rf_rd,
  output logic [3:0]            rf_shamt,
  output logic [15:0]           rf_wdata,
  input  logic                  rf_done,
  output logic                  busy,
  output logic                  retire_valid,
  output logic [2:0]            retire_op,
  output logic [CYC_W-1:0]      retire_cycles,
  output logic [15:0]           retired_cnt,
  output logic                  error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PKT_W = 3 + 5 + 5 + 5 + 4 + 16;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("regfile_issue_ctrl: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << CYC_W) - 1) begin : g_timeout_chk
    $error("regfile_issue_ctrl: TIMEOUT must fit in CYC_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_n;
  logic             ready_q;
  logic             push, pop;
  logic [CYC_W-1:0] cyc_q, cyc_inc;
  logic             timeout_hit;
  logic             retire_now;

  // ready is registered so it stays low through reset and rises on the
  // first edge after reset is released.
  assign push = instr.instr_valid && ready_q;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign instr.instr_ready = ready_q;

  always_comb begin
    count_n = count;
    if (flush)
      count_n = '0;
    else if (push && !pop)
      count_n = count + (AW+1)'(1);
    else if (!push && pop)
      count_n = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_n;
      ready_q <= (count_n != FULL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {instr.instr_op, instr.instr_rs1, instr.instr_rs2,
                      instr.instr_rd, instr.instr_shamt, instr.instr_data};
  end

  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

`ifdef WATCHDOG_EN
  logic err_q;
  assign timeout_hit = (cyc_inc == CYC_W'(TIMEOUT));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == S_EXEC && timeout_hit && !rf_done)
      err_q <= 1'b1;
  end
  assign error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (count != '0) state_n = S_EXEC;
      S_EXEC:   if (rf_done || timeout_hit) state_n = S_RETIRE;
      S_RETIRE: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign retire_now = (state == S_EXEC) && (state_n == S_RETIRE);

  // The counter includes the rf_done cycle and is frozen through RETIRE,
  // so it doubles as retire_cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_op       <= '0;
      rf_rs1      <= '0;
      rf_rs2      <= '0;
      rf_rd       <= '0;
      rf_shamt    <= '0;
      rf_wdata    <= '0;
      cyc_q       <= '0;
      retired_cnt <= '0;
    end else begin
      if (pop) begin
        {rf_op, rf_rs1, rf_rs2, rf_rd, rf_shamt, rf_wdata} <= mem[rd_ptr];
        cyc_q <= '0;
      end else if (state == S_EXEC) begin
        cyc_q <= cyc_inc;
      end
      if (retire_now)
        retired_cnt <= retired_cnt + 16'd1;
    end
  end

  assign rf_op_valid   = (state == S_EXEC);
  assign retire_valid  = (state == S_RETIRE);
  assign retire_op     = rf_op;
  assign retire_cycles = cyc_q;
  assign busy          = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// tb/tb_regfile_issue_ctrl.sv - self-checking bench for regfile_issue_ctrl
module tb_regfile_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int CYC_W   = 8;
  localparam int TIMEOUT = 32;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_issue_ctrl_if ifc();
  logic             flush = 1'b0;
  logic             rf_done = 1'b0;
  logic             rf_op_valid, busy, retire_valid, error;
  logic [2:0]       rf_op, retire_op;
  logic [4:0]       rf_rs1, rf_rs2, rf_rd;
  logic [3:0]       rf_shamt;
  logic [15:0]      rf_wdata, retired_cnt;
  logic [CYC_W-1:0] retire_cycles;

  regfile_issue_ctrl #(.DEPTH(DEPTH), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(ifc), .flush(flush),
    .rf_op_valid(rf_op_valid), .rf_op(rf_op), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_shamt(rf_shamt), .rf_wdata(rf_wdata), .rf_done(rf_done),
    .busy(busy), .retire_valid(retire_valid), .retire_op(retire_op),
    .retire_cycles(retire_cycles), .retired_cnt(retired_cnt), .error(error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  sh;
    logic [15:0] d;
    int          lat;   // EXEC cycle carrying rf_done; 0 = never
  } pkt_t;

  pkt_t exp_q[$];       // accepted packets not yet retired, in order
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ret = 0;
  int   ecnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_cycles(input int lat);
    int c = lat;
    if (WD && (lat == 0 || lat > TIMEOUT)) c = TIMEOUT;
    if (c > 255) c = 255;
    return c;
  endfunction

  // Datapath model: pulses rf_done in the lat-th EXEC cycle of the head op.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !rf_op_valid) begin
        ecnt = 0;
        rf_done = 1'b0;
      end else begin
        ecnt++;
        rf_done = (exp_q.size() > 0) && (exp_q[0].lat != 0) && (ecnt == exp_q[0].lat);
      end
    end
  end

  // Scoreboard: issued operands and retirements against the in-order queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_op_valid) begin
          chk("issue_has_packet", exp_q.size() > 0, 1);
          if (exp_q.size() > 0)
            chk("issue_operands", {rf_op, rf_rs1, rf_rs2, rf_rd, rf_shamt, rf_wdata},
                {exp_q[0].op, exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rd, exp_q[0].sh, exp_q[0].d});
        end
        if (retire_valid) begin
          chk("retire_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            n_ret++;
            chk("retire_op", retire_op, exp_q[0].op);
            chk("retire_cycles", retire_cycles, exp_cycles(exp_q[0].lat));
            chk("retired_cnt", retired_cnt, n_ret & 16'hffff);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Call at a negedge; returns at the negedge after acceptance with valid still high.
  task automatic push(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [3:0] sh, input logic [15:0] d,
                      input int lat);
    bit   acc = 0;
    pkt_t p;
    p.op = op; p.rs1 = rs1; p.rs2 = rs2; p.rd = rd; p.sh = sh; p.d = d; p.lat = lat;
    ifc.instr_valid = 1'b1;
    ifc.instr_op = op; ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2;
    ifc.instr_rd = rd; ifc.instr_shamt = sh; ifc.instr_data = d;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = ifc.instr_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(p);
      @(negedge clk);
    end
    chk("push_accepted", acc, 1);
  endtask

  task automatic push_rand(input int lat);
    push(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
         16'($urandom), lat);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1500 && busy; i++) @(negedge clk);
    chk("drain_done", busy, 0);
  endtask

  task automatic wait_retire();
    for (int i = 0; i < 200 && !retire_valid; i++) @(negedge clk);
    chk("retire_seen", retire_valid, 1);
  endtask

  initial begin
    int nv;
    ifc.instr_valid = 1'b0;
    ifc.instr_op = '0; ifc.instr_rs1 = '0; ifc.instr_rs2 = '0;
    ifc.instr_rd = '0; ifc.instr_shamt = '0; ifc.instr_data = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", ifc.instr_ready, 0);
    chk("rst_rf_valid", rf_op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retired_cnt", retired_cnt, 0);
    chk("rst_error", error, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    #2 rst = 1'b0;
    #1 chk("ready_before_edge", ifc.instr_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", ifc.instr_ready, 1);

    // Single write op, done in 3rd EXEC cycle
    push(3'b000, 5'd1, 5'd2, 5'd3, 4'd0, 16'h00AB, 3);
    ifc.instr_valid = 1'b0;
    chk("t1_not_yet_valid", rf_op_valid, 0);
    @(negedge clk);
    chk("t1_valid", rf_op_valid, 1);
    chk("t1_rd", rf_rd, 3);
    chk("t1_wdata", rf_wdata, 16'h00AB);
    nv = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!rf_op_valid) break;
      nv++;
    end
    chk("t1_valid_cycles", nv, 3);
    chk("t1_retire_valid", retire_valid, 1);
    chk("t1_retire_cycles", retire_cycles, 3);
    chk("t1_retired_cnt", retired_cnt, 1);
    wait_drain();

    // FIFO fill while datapath stalls
    push(3'b010, 5'd4, 5'd5, 5'd6, 4'd1, 16'h1234, 30);
    ifc.instr_valid = 1'b0;
    for (int i = 0; i < 10 && !rf_op_valid; i++) @(negedge clk);
    chk("t2_exec", rf_op_valid, 1);
    for (int k = 0; k < 4; k++) push_rand(2 + k);
    ifc.instr_valid = 1'b0;
    chk("t2_full_ready", ifc.instr_ready, 0);
    push_rand(6);
    ifc.instr_valid = 1'b0;
    wait_drain();
    chk("t2_retired_cnt", retired_cnt, 7);

    // Add op with push and pop on the same edge
    push(3'b101, 5'd7, 5'd8, 5'd9, 4'd2, 16'hBEEF, 21);
    push_rand(2);
    ifc.instr_valid = 1'b0;
    chk("t3_exec", rf_op_valid, 1);
    for (int k = 0; k < 3; k++) push_rand(2);
    ifc.instr_valid = 1'b0;
    chk("t3_full_after_simul", ifc.instr_ready, 0);
    wait_drain();
    chk("t3_retired_cnt", retired_cnt, 12);

    // Flush during an op-111 EXEC with 3 queued
    push(3'b111, 5'd10, 5'd11, 5'd12, 4'd5, 16'h5A5A, 15);
    for (int k = 0; k < 3; k++) push_rand(3);
    ifc.instr_valid = 1'b0;
    chk("t4_exec_op", {rf_op_valid, rf_op}, 4'b1111);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    chk("t4_ready_after_flush", ifc.instr_ready, 1);
    chk("t4_busy_in_exec", busy, 1);
    wait_retire();
    @(negedge clk);
    chk("t4_busy_idle", busy, 0);
    @(negedge clk);
    chk("t4_no_issue", rf_op_valid, 0);
    chk("t4_retired_cnt", retired_cnt, 13);

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      push_rand($urandom_range(1, 12));
      if ($urandom_range(0, 2) == 0) begin
        ifc.instr_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    ifc.instr_valid = 1'b0;
    wait_drain();
    chk("rand_retired_cnt", retired_cnt, 37);

`ifdef WATCHDOG_EN
    push(3'b110, 5'd1, 5'd1, 5'd1, 4'd3, 16'h0F0F, 0);
    ifc.instr_valid = 1'b0;
    wait_retire();
    chk("wd_retire_cycles", retire_cycles, TIMEOUT);
    chk("wd_error", error, 1);
    @(negedge clk);
    push(3'b001, 5'd2, 5'd3, 5'd4, 4'd0, 16'h1111, 4);
    ifc.instr_valid = 1'b0;
    wait_drain();
    chk("wd_error_sticky", error, 1);
    chk("wd_retired_cnt", retired_cnt, 39);
`else
    chk("no_wd_error", error, 0);
`endif

    // Reset in the middle of an EXEC
    push(3'b101, 5'd3, 5'd3, 5'd3, 4'd1, 16'h7777, 21);
    ifc.instr_valid = 1'b0;
    for (int i = 0; i < 40 && ecnt != 10; i++) @(negedge clk);
    chk("rst_mid_reached", ecnt, 10);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rf_valid", rf_op_valid, 0);
    chk("rst_mid_ready", ifc.instr_ready, 0);
    chk("rst_mid_retired_cnt", retired_cnt, 0);
    exp_q.delete();
    n_ret = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_retire_valid", retire_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_back", ifc.instr_ready, 1);
    repeat (30) @(negedge clk);
    chk("rst_mid_no_retire_cnt", retired_cnt, 0);
    chk("rst_mid_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
